// File: rtl/i2c_slave_fsm.sv
// i2c_slave_fsm: single-address I2C target oversampled in the system clock domain.
// Detects START/STOP, ACKs its address and captures up to two written bytes
// or returns two read bytes.
// Optional glitch filter on the synchronised lines: define I2C_SLAVE_GLITCH_FILTER_EN.
// dbg_state exposes the FSM state (IDLE reads as 0).
module i2c_slave_fsm #(
  parameter int                  ADDR_LEN   = 7,
  parameter int                  DATA_LEN   = 8,
  parameter logic [ADDR_LEN-1:0] SLAVE_ADDR = 7'h52,
  parameter int                  SDA_HOLD   = 1,
  parameter int                  FILTER_LEN = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scl,
  inout  wire                 sda,
  input  logic [DATA_LEN-1:0] tx_data_1,
  input  logic [DATA_LEN-1:0] tx_data_2,
  output logic [DATA_LEN-1:0] rx_data_1,
  output logic [DATA_LEN-1:0] rx_data_2,
  output logic [1:0]          rx_count,
  output logic                busy,
  output logic                done,
  output logic [2:0]          dbg_state
);

  localparam int SH_W  = (ADDR_LEN + 1 > DATA_LEN) ? ADDR_LEN + 1 : DATA_LEN;
  localparam int CNT_W = $clog2(SH_W + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_WR_DATA   = 3'd3,
    S_WR_ACK    = 3'd4,
    S_RD_DATA   = 3'd5,
    S_RD_ACK    = 3'd6,
    S_WAIT_STOP = 3'd7
  } state_t;

  logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
  logic scl_v, sda_v, scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_det, stop_det, drive_tick;
  logic [1:0] hold_cnt_q;
  logic       hold_act_q;

  // Two-flop synchronisers; the bus idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      scl_s1_q <= scl;
      scl_s2_q <= scl_s1_q;
      sda_s1_q <= sda;
      sda_s2_q <= sda_s1_q;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);
  logic [FCW-1:0] scl_fcnt_q, sda_fcnt_q;
  logic           scl_f_q, sda_f_q;

  // A filtered line only follows after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_fcnt_q <= '0;
      sda_fcnt_q <= '0;
    end else begin
      if (scl_s2_q == scl_f_q) begin
        scl_fcnt_q <= '0;
      end else if (scl_fcnt_q == FCW'(FILTER_LEN - 1)) begin
        scl_f_q    <= scl_s2_q;
        scl_fcnt_q <= '0;
      end else begin
        scl_fcnt_q <= scl_fcnt_q + 1'b1;
      end
      if (sda_s2_q == sda_f_q) begin
        sda_fcnt_q <= '0;
      end else if (sda_fcnt_q == FCW'(FILTER_LEN - 1)) begin
        sda_f_q    <= sda_s2_q;
        sda_fcnt_q <= '0;
      end else begin
        sda_fcnt_q <= sda_fcnt_q + 1'b1;
      end
    end
  end

  assign scl_v = scl_f_q;
  assign sda_v = sda_f_q;
`else
  // No filter: the synchronised lines are used directly.
  assign scl_v = scl_s2_q;
  assign sda_v = sda_s2_q;
  // FILTER_LEN only shapes the filtered build; this empty block keeps it referenced.
  if (FILTER_LEN < 0) begin : g_filter_len_ref
  end
`endif

  assign scl_rise  = scl_v & ~scl_prev_q;
  assign scl_fall  = ~scl_v & scl_prev_q;
  assign start_det = scl_v & scl_prev_q & sda_prev_q & ~sda_v;
  assign stop_det  = scl_v & scl_prev_q & ~sda_prev_q & sda_v;
  assign drive_tick = (SDA_HOLD == 0) ? scl_fall : (hold_act_q && hold_cnt_q == 2'd1);

  // Previous line values and the SDA_HOLD delay from a detected SCL fall
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      hold_cnt_q <= '0;
      hold_act_q <= 1'b0;
    end else begin
      scl_prev_q <= scl_v;
      sda_prev_q <= sda_v;
      if (scl_fall) begin
        hold_cnt_q <= 2'(SDA_HOLD);
        hold_act_q <= (SDA_HOLD != 0);
      end else if (hold_act_q) begin
        hold_cnt_q <= hold_cnt_q - 1'b1;
        if (hold_cnt_q == 2'd1) hold_act_q <= 1'b0;
      end
    end
  end

  state_t              state_q, state_d;
  logic [SH_W-2:0]     sh_q, sh_d;
  logic [SH_W-1:0]     sh_shift;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                rw_q, rw_d, byte_sel_q, byte_sel_d, next_q, next_d;
  logic [DATA_LEN-1:0] tx_sh_q, tx_sh_d, tx_buf2_q, tx_buf2_d;
  logic [DATA_LEN-1:0] rx1_q, rx1_d, rx2_q, rx2_d;
  logic [1:0]          rx_cnt_q, rx_cnt_d;
  logic                oe_q, oe_d, busy_q, busy_d, done_q, done_d;

  assign sh_shift = {sh_q, sda_v};

  // FSM state and datapath registers; reset releases sda immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      rw_q       <= 1'b0;
      byte_sel_q <= 1'b0;
      next_q     <= 1'b0;
      tx_sh_q    <= '0;
      tx_buf2_q  <= '0;
      rx1_q      <= '0;
      rx2_q      <= '0;
      rx_cnt_q   <= '0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      rw_q       <= rw_d;
      byte_sel_q <= byte_sel_d;
      next_q     <= next_d;
      tx_sh_q    <= tx_sh_d;
      tx_buf2_q  <= tx_buf2_d;
      rx1_q      <= rx1_d;
      rx2_q      <= rx2_d;
      rx_cnt_q   <= rx_cnt_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; STOP and START take priority over every state
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    rw_d       = rw_q;
    byte_sel_d = byte_sel_q;
    next_d     = next_q;
    tx_sh_d    = tx_sh_q;
    tx_buf2_d  = tx_buf2_q;
    rx1_d      = rx1_q;
    rx2_d      = rx2_q;
    rx_cnt_d   = rx_cnt_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (stop_det) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = busy_q;
    end else if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      rx_cnt_d  = '0;
      oe_d      = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          sh_d      = sh_shift[SH_W-2:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(ADDR_LEN)) begin
            bit_cnt_d = '0;
            rw_d      = sh_shift[0];
            if (sh_shift[ADDR_LEN:1] == SLAVE_ADDR) begin
              state_d = S_ADDR_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        // First tick after the 8th fall drives ACK, the next one ends it
        S_ADDR_ACK: if (drive_tick) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else if (rw_q) begin
            state_d    = S_RD_DATA;
            tx_sh_d    = tx_data_1;
            tx_buf2_d  = tx_data_2;
            byte_sel_d = 1'b0;
            bit_cnt_d  = '0;
            oe_d       = ~tx_data_1[DATA_LEN-1];
          end else begin
            state_d   = S_WR_DATA;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
          end
        end
        S_WR_DATA: if (scl_rise) begin
          sh_d      = sh_shift[SH_W-2:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(DATA_LEN - 1)) begin
            bit_cnt_d = '0;
            if (rx_cnt_q == 2'd0) begin
              rx1_d    = sh_shift[DATA_LEN-1:0];
              rx_cnt_d = 2'd1;
              state_d  = S_WR_ACK;
            end else if (rx_cnt_q == 2'd1) begin
              rx2_d    = sh_shift[DATA_LEN-1:0];
              rx_cnt_d = 2'd2;
              state_d  = S_WR_ACK;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        S_WR_ACK: if (drive_tick) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else begin
            state_d   = S_WR_DATA;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
          end
        end
        // MSB is already on the bus at entry; each tick presents the next bit
        S_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (drive_tick) begin
            if (bit_cnt_q == CNT_W'(DATA_LEN)) begin
              state_d = S_RD_ACK;
              oe_d    = 1'b0;
              next_d  = 1'b0;
            end else begin
              tx_sh_d = tx_sh_q << 1;
              oe_d    = ~tx_sh_q[DATA_LEN-2];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_v && !byte_sel_q) next_d = 1'b1;
            else state_d = S_WAIT_STOP;
          end else if (drive_tick && next_q) begin
            state_d    = S_RD_DATA;
            tx_sh_d    = tx_buf2_q;
            byte_sel_d = 1'b1;
            bit_cnt_d  = '0;
            oe_d       = ~tx_buf2_q[DATA_LEN-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign sda       = oe_q ? 1'b0 : 1'bz;
  assign rx_data_1 = rx1_q;
  assign rx_data_2 = rx2_q;
  assign rx_count  = rx_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Bench for i2c_slave_fsm: bit-banged I2C master, transaction-level model of
// the target (acks, captured bytes, byte count, done pulses), directed plus
// randomised transfers.
module tb_i2c_slave_fsm;
  localparam int         Q     = 5;      // quarter SCL period in clocks
  localparam logic [6:0] SLAVE = 7'h52;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda_oe;
  wire        sda;
  logic [7:0] tx_data_1, tx_data_2, rx_data_1, rx_data_2;
  logic [1:0] rx_count;
  logic       busy, done;
  logic [2:0] dbg_state;

  int         checks = 0, errors = 0;
  int         done_cnt = 0, overlap = 0;
  logic [7:0] exp_rx1, exp_rx2;
  int         exp_cnt, exp_done;
  bit         exp_busy;

  pullup (sda);
  assign sda = m_sda_oe ? 1'b0 : 1'bz;

  // Clock
  always #5 clk = ~clk;

  i2c_slave_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (m_scl),
    .sda       (sda),
    .tx_data_1 (tx_data_1),
    .tx_data_2 (tx_data_2),
    .rx_data_1 (rx_data_1),
    .rx_data_2 (rx_data_2),
    .rx_count  (rx_count),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Count done pulses and any cycle where done and busy are both high
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (done && busy) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sda(input logic v);
    m_sda_oe = ~v;
  endtask

  task automatic write_bit(input logic b, input bit glitch);
    set_sda(b);
    wait_clks(Q);
    m_scl = 1'b1;
    if (glitch) begin
      wait_clks(Q - 1);
      m_scl = 1'b0;
      wait_clks(1);
      m_scl = 1'b1;
      wait_clks(Q);
    end else begin
      wait_clks(2 * Q);
    end
    m_scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic read_bit(output logic b);
    set_sda(1'b1);
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(Q);
    b = sda;
    wait_clks(Q);
    m_scl = 1'b0;
    wait_clks(Q);
  endtask

  // Works from idle (both high) and as a repeated START (SCL low)
  task automatic i2c_start();
    set_sda(1'b1);
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(Q);
    set_sda(1'b0);
    wait_clks(Q);
    m_scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_stop();
    set_sda(1'b0);
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(Q);
    set_sda(1'b1);
    wait_clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_at, output logic ack);
    logic nb;
    for (int i = 7; i >= 0; i--) write_bit(b[i], i == glitch_at);
    read_bit(nb);
    ack = ~nb;
  endtask

  task automatic recv_byte(input bit ack_it, output logic [7:0] b);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      b[i] = v;
    end
    write_bit(~ack_it, 1'b0);
  endtask

  // Write transfer without the STOP; the model keeps only the first two bytes
  task automatic xfer_write(input logic [6:0] addr, input int n, input logic [7:0] d0,
                            input logic [7:0] d1, input logic [7:0] d2, input int glitch_at);
    logic [7:0] d [3];
    logic       ack;
    bit         match;
    d[0] = d0; d[1] = d1; d[2] = d2;
    match = (addr == SLAVE);
    i2c_start();
    exp_cnt = 0;
    send_byte({addr, 1'b0}, -1, ack);
    check("wr_addr_ack", ack, match);
    exp_busy = exp_busy | match;
    check("wr_busy", busy, exp_busy);
    if (match) begin
      for (int k = 0; k < n; k++) begin
        send_byte(d[k], (k == 0) ? glitch_at : -1, ack);
        check("wr_data_ack", ack, k < 2);
        if (k == 0) exp_rx1 = d[0];
        if (k == 1) exp_rx2 = d[1];
        if (k < 2) exp_cnt = k + 1;
        if (!ack) break;
      end
    end
  endtask

  // Read transfer without the STOP; master ACKs byte 1 only when nb is 2
  task automatic xfer_read(input logic [6:0] addr, input int nb, input logic [7:0] t1,
                           input logic [7:0] t2);
    logic       ack;
    logic [7:0] b;
    bit         match;
    tx_data_1 = t1;
    tx_data_2 = t2;
    match = (addr == SLAVE);
    i2c_start();
    exp_cnt = 0;
    send_byte({addr, 1'b1}, -1, ack);
    check("rd_addr_ack", ack, match);
    exp_busy = exp_busy | match;
    check("rd_busy", busy, exp_busy);
    if (match) begin
      recv_byte(nb > 1, b);
      check("rd_byte1", b, t1);
      // Both bytes were captured when byte 1 started; later input changes are ignored
      tx_data_1 = ~t1;
      tx_data_2 = ~t2;
      if (nb > 1) begin
        recv_byte(1'b0, b);
        check("rd_byte2", b, t2);
      end
      check("rd_release", sda, 1'b1);
    end
  endtask

  task automatic xfer_stop();
    i2c_stop();
    wait_clks(12);
    if (exp_busy) exp_done++;
    exp_busy = 1'b0;
    check("done_count", done_cnt, exp_done);
    check("busy_after_stop", busy, 1'b0);
    check("state_idle", dbg_state, 3'd0);
    check("rx_data_1", rx_data_1, exp_rx1);
    check("rx_data_2", rx_data_2, exp_rx2);
    check("rx_count", rx_count, exp_cnt);
  endtask

  initial begin
    logic [6:0] a;
    logic       ack;
    logic       v;
    // Reset
    rst = 1'b1; m_scl = 1'b1; m_sda_oe = 1'b0;
    tx_data_1 = '0; tx_data_2 = '0;
    exp_rx1 = '0; exp_rx2 = '0; exp_cnt = 0; exp_done = 0; exp_busy = 1'b0;
    wait_clks(4);
    check("rst_sda", sda, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    check("rst_rx_count", rx_count, 2'd0);
    check("rst_rx_data_1", rx_data_1, 8'h00);
    check("rst_rx_data_2", rx_data_2, 8'h00);
    rst = 1'b0;
    wait_clks(6);

    // Matched write of two bytes
    xfer_write(SLAVE, 2, 8'hA5, 8'h3C, 8'h00, -1);
    xfer_stop();

    // Matched read
    xfer_read(SLAVE, 2, 8'h81, 8'h7E);
    xfer_stop();

    // Address mismatch
    xfer_write(7'h23, 2, 8'h55, 8'h66, 8'h00, -1);
    xfer_stop();

    // Overrun: third byte NACKed
    xfer_write(SLAVE, 3, 8'h11, 8'h22, 8'h33, -1);
    xfer_stop();

    // Repeated START: write one byte, then read without an intervening STOP
    xfer_write(SLAVE, 1, 8'hC3, 8'h00, 8'h00, -1);
    check("rs_no_done", done_cnt, exp_done);
    xfer_read(SLAVE, 2, 8'h5A, 8'hF0);
    check("rs_no_done_2", done_cnt, exp_done);
    xfer_stop();

    // Reset during bit 3 of a read byte (0x81: third bit is 0, driven low)
    tx_data_1 = 8'h81;
    tx_data_2 = 8'h7E;
    i2c_start();
    send_byte({SLAVE, 1'b1}, -1, ack);
    check("mr_addr_ack", ack, 1'b1);
    read_bit(v);
    read_bit(v);
    set_sda(1'b1);
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(Q);
    check("mr_driving", sda, 1'b0);
    rst = 1'b1;
    wait_clks(1);
    check("mr_sda_release", sda, 1'b1);
    check("mr_state", dbg_state, 3'd0);
    check("mr_busy", busy, 1'b0);
    check("mr_done", done, 1'b0);
    check("mr_rx_count", rx_count, 2'd0);
    check("mr_rx_data_1", rx_data_1, 8'h00);
    check("mr_rx_data_2", rx_data_2, 8'h00);
    wait_clks(1);
    rst = 1'b0;
    exp_rx1 = '0; exp_rx2 = '0; exp_cnt = 0; exp_busy = 1'b0;
    wait_clks(10);
    xfer_write(SLAVE, 2, 8'h9C, 8'h47, 8'h00, -1);
    xfer_stop();

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // One-clock low glitch on SCL during bit 4 of the data byte
    xfer_write(SLAVE, 1, 8'h96, 8'h00, 8'h00, 4);
    xfer_stop();
`endif

    // Randomised transfers against the model
    for (int it = 0; it < 12; it++) begin
      a = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : SLAVE;
      if ($urandom_range(0, 1) == 1)
        xfer_write(a, $urandom_range(0, 3), 8'($urandom), 8'($urandom), 8'($urandom), -1);
      else
        xfer_read(a, $urandom_range(1, 2), 8'($urandom), 8'($urandom));
      xfer_stop();
    end

    check("done_busy_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
